// File: rtl/polyshift_pipe_pkg.sv
// Shared shift-mode encodings for the poly-shifter family and a latency helper
// used to size the register pipeline.
package polyshift_pipe_pkg;

    typedef enum logic [1:0] {
        LOGIC = 2'd0,
        ARITH = 2'd1,
        RCL   = 2'd2,
        ROL   = 2'd3
    } shift_type_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } shift_dir_t;

    // Number of register boundaries when grouping log2(W) shift stages
    function automatic int unsigned pipe_latency(input int unsigned word_width,
                                                 input int unsigned stages_per_reg);
        return ($clog2(word_width) + stages_per_reg - 1) / stages_per_reg;
    endfunction

endpackage

// File: rtl/polyshift_pipe_if.sv
// Operand/result handshake bundle of the pipelined poly-shifter; the shifter is
// the slave, the execute path around it is the master.
interface polyshift_pipe_if
    import polyshift_pipe_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 8
);
    localparam int unsigned SIZE_W = $clog2(WORD_WIDTH);

    logic                  valid_i;
    logic                  ready_o;
    logic [WORD_WIDTH-1:0] d_i;
    logic [WORD_WIDTH-2:0] c_i;
    logic [SIZE_W-1:0]     shift_size_i;
    shift_type_t           shift_type_i;
    shift_dir_t            shift_dir_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [WORD_WIDTH-1:0] d_o;
    logic                  carry_o;

    modport master (
        output valid_i, d_i, c_i, shift_size_i, shift_type_i, shift_dir_i, ready_i,
        input  ready_o, valid_o, d_o, carry_o
    );

    modport slave (
        input  valid_i, d_i, c_i, shift_size_i, shift_type_i, shift_dir_i, ready_i,
        output ready_o, valid_o, d_o, carry_o
    );

endinterface

// File: rtl/polyshift_pipe_stage.sv
// One combinational 2^STEP shift stage: moves the data word (and, for RCL, the
// fill word) and updates the running carry when its size bit is set.
module polyshift_pipe_stage
    import polyshift_pipe_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned STEP       = 0
) (
    input  logic [WORD_WIDTH-1:0] d_i,
    input  logic [WORD_WIDTH-2:0] c_i,
    input  logic                  carry_i,
    input  shift_type_t           type_i,
    input  shift_dir_t            dir_i,
    input  logic                  en_i,
    output logic [WORD_WIDTH-1:0] d_o,
    output logic [WORD_WIDTH-2:0] c_o,
    output logic                  carry_o
);
    localparam int unsigned AMT    = 1 << STEP;
    localparam int unsigned FILL_W = WORD_WIDTH - 1;
    localparam int unsigned DW     = 2 * WORD_WIDTH - 1;

    // RCL treats data and fill as one double-precision word; order depends on direction
    logic [DW-1:0] dc_l;
    logic [DW-1:0] cd_r;

    assign dc_l = {d_i, c_i} << AMT;
    assign cd_r = {c_i, d_i} >> AMT;

    always_comb begin
        d_o     = d_i;
        c_o     = c_i;
        carry_o = carry_i;
        if (en_i) begin
            if (dir_i == LEFT) begin
                carry_o = d_i[WORD_WIDTH-AMT];
                case (type_i)
                    LOGIC, ARITH: d_o = d_i << AMT;
                    RCL: begin
                        d_o = dc_l[DW-1 -: WORD_WIDTH];
                        c_o = dc_l[FILL_W-1:0];
                    end
                    ROL:     d_o = (d_i << AMT) | (d_i >> (WORD_WIDTH - AMT));
                    default: d_o = d_i;
                endcase
            end else begin
                carry_o = d_i[AMT-1];
                case (type_i)
                    LOGIC: d_o = d_i >> AMT;
                    ARITH: d_o = WORD_WIDTH'($signed(d_i) >>> AMT);
                    RCL: begin
                        d_o = cd_r[WORD_WIDTH-1:0];
                        c_o = cd_r[DW-1:WORD_WIDTH];
                    end
                    ROL:     d_o = (d_i >> AMT) | (d_i << (WORD_WIDTH - AMT));
                    default: d_o = d_i;
                endcase
            end
        end
    end

endmodule

// File: rtl/polyshift_pipe.sv
// Pipelined bidirectional multi-mode shifter: log2(W) shift stages with a
// register every STAGES_PER_REG stages and a globally stalled valid/ready pipe.
module polyshift_pipe
    import polyshift_pipe_pkg::*;
#(
    parameter int unsigned WORD_WIDTH     = 8,
    parameter int unsigned STAGES_PER_REG = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    polyshift_pipe_if.slave bus
);
    localparam int unsigned NUM_STAGES = $clog2(WORD_WIDTH);
    localparam int unsigned SIZE_W     = NUM_STAGES;
    localparam int unsigned FILL_W     = WORD_WIDTH - 1;
    localparam int unsigned LATENCY    = pipe_latency(WORD_WIDTH, STAGES_PER_REG);

    // Stage inputs (_s) and stage outputs (_d, next-state of the group registers)
    logic [WORD_WIDTH-1:0] d_s     [NUM_STAGES];
    logic [FILL_W-1:0]     c_s     [NUM_STAGES];
    logic                  carry_s [NUM_STAGES];
    shift_type_t           type_s  [NUM_STAGES];
    shift_dir_t            dir_s   [NUM_STAGES];
    logic [SIZE_W-1:0]     size_s  [NUM_STAGES];
    logic                  vld_s   [NUM_STAGES];

    logic [WORD_WIDTH-1:0] d_d     [NUM_STAGES];
    logic [FILL_W-1:0]     c_d     [NUM_STAGES];
    logic                  carry_d [NUM_STAGES];

    logic                  adv_c;
    logic                  valid_q;
    logic [WORD_WIDTH-1:0] dout_q;
    logic                  carry_q;

    // Whole pipe moves together; no bubble collapsing
    assign adv_c       = !valid_q || bus.ready_i;
    assign bus.ready_o = adv_c;
    assign bus.valid_o = valid_q;
    assign bus.d_o     = dout_q;
    assign bus.carry_o = carry_q;

    assign d_s[0]     = bus.d_i;
    assign c_s[0]     = bus.c_i;
    assign carry_s[0] = 1'b0;
    assign type_s[0]  = bus.shift_type_i;
    assign dir_s[0]   = bus.shift_dir_i;
    assign size_s[0]  = bus.shift_size_i;
    assign vld_s[0]   = bus.valid_i;

    for (genvar n = 0; n < NUM_STAGES; n++) begin : g_stage
        polyshift_pipe_stage #(
            .WORD_WIDTH (WORD_WIDTH),
            .STEP       (n)
        ) u_stage (
            .d_i     (d_s[n]),
            .c_i     (c_s[n]),
            .carry_i (carry_s[n]),
            .type_i  (type_s[n]),
            .dir_i   (dir_s[n]),
            .en_i    (|(size_s[n] & SIZE_W'(1 << n))),
            .d_o     (d_d[n]),
            .c_o     (c_d[n]),
            .carry_o (carry_d[n])
        );

        // Stages inside a register group chain combinationally
        if ((n + 1 < NUM_STAGES) && (((n + 1) % STAGES_PER_REG) != 0)) begin : g_link
            assign d_s[n+1]     = d_d[n];
            assign c_s[n+1]     = c_d[n];
            assign carry_s[n+1] = carry_d[n];
            assign type_s[n+1]  = type_s[n];
            assign dir_s[n+1]   = dir_s[n];
            assign size_s[n+1]  = size_s[n];
            assign vld_s[n+1]   = vld_s[n];
        end
    end

    for (genvar r = 0; r < LATENCY; r++) begin : g_reg
        localparam int unsigned LAST =
            ((((r + 1) * STAGES_PER_REG) < NUM_STAGES) ? ((r + 1) * STAGES_PER_REG)
                                                       : NUM_STAGES) - 1;

        if (r == LATENCY - 1) begin : g_out
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                    dout_q  <= '0;
                    carry_q <= 1'b0;
                end else if (adv_c) begin
                    valid_q <= vld_s[LAST];
                    dout_q  <= d_d[LAST];
                    carry_q <= carry_d[LAST];
                end
            end
        end else begin : g_mid
            logic [WORD_WIDTH-1:0] d_q;
            logic [FILL_W-1:0]     c_q;
            logic                  carry_q_m;
            shift_type_t           type_q;
            shift_dir_t            dir_q;
            logic [SIZE_W-1:0]     size_q;
            logic                  vld_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    d_q       <= '0;
                    c_q       <= '0;
                    carry_q_m <= 1'b0;
                    type_q    <= LOGIC;
                    dir_q     <= LEFT;
                    size_q    <= '0;
                    vld_q     <= 1'b0;
                end else if (adv_c) begin
                    d_q       <= d_d[LAST];
                    c_q       <= c_d[LAST];
                    carry_q_m <= carry_d[LAST];
                    type_q    <= type_s[LAST];
                    dir_q     <= dir_s[LAST];
                    size_q    <= size_s[LAST];
                    vld_q     <= vld_s[LAST];
                end
            end

            assign d_s[LAST+1]     = d_q;
            assign c_s[LAST+1]     = c_q;
            assign carry_s[LAST+1] = carry_q_m;
            assign type_s[LAST+1]  = type_q;
            assign dir_s[LAST+1]   = dir_q;
            assign size_s[LAST+1]  = size_q;
            assign vld_s[LAST+1]   = vld_q;
        end
    end

endmodule

// File: tb/tb_polyshift_pipe.sv
// Directed and exhaustive checks of polyshift_pipe at W=8 for 1, 2 and 3 stages
// per register, all three copies driven from one stimulus bundle.
module tb_polyshift_pipe;
    import polyshift_pipe_pkg::*;

    localparam int unsigned W = 8;
    localparam int N_SWEEP = 16384;

    localparam logic [7:0] B2B_D [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    localparam logic [7:0] B2B_E [8] = '{8'h08, 8'h19, 8'h2A, 8'h3B, 8'h4C, 8'h5D, 8'h6E, 8'h7F};
    localparam logic       B2B_C [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_i;
    logic [7:0]  d_i;
    logic [6:0]  c_i;
    logic [2:0]  size_i;
    shift_type_t type_i;
    shift_dir_t  dir_i;

    logic        vo   [3];
    logic        ro   [3];
    logic [7:0]  dout [3];
    logic        co   [3];

    logic [8:0]  exp_arr [N_SWEEP];
    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk = ~clk;

    polyshift_pipe_if #(.WORD_WIDTH(W)) if1 ();
    polyshift_pipe_if #(.WORD_WIDTH(W)) if2 ();
    polyshift_pipe_if #(.WORD_WIDTH(W)) if3 ();

    assign if1.valid_i = valid_i;  assign if2.valid_i = valid_i;  assign if3.valid_i = valid_i;
    assign if1.ready_i = ready_i;  assign if2.ready_i = ready_i;  assign if3.ready_i = ready_i;
    assign if1.d_i = d_i;          assign if2.d_i = d_i;          assign if3.d_i = d_i;
    assign if1.c_i = c_i;          assign if2.c_i = c_i;          assign if3.c_i = c_i;
    assign if1.shift_size_i = size_i;
    assign if2.shift_size_i = size_i;
    assign if3.shift_size_i = size_i;
    assign if1.shift_type_i = type_i;
    assign if2.shift_type_i = type_i;
    assign if3.shift_type_i = type_i;
    assign if1.shift_dir_i = dir_i;
    assign if2.shift_dir_i = dir_i;
    assign if3.shift_dir_i = dir_i;

    assign vo[0] = if1.valid_o;  assign vo[1] = if2.valid_o;  assign vo[2] = if3.valid_o;
    assign ro[0] = if1.ready_o;  assign ro[1] = if2.ready_o;  assign ro[2] = if3.ready_o;
    assign dout[0] = if1.d_o;    assign dout[1] = if2.d_o;    assign dout[2] = if3.d_o;
    assign co[0] = if1.carry_o;  assign co[1] = if2.carry_o;  assign co[2] = if3.carry_o;

    polyshift_pipe #(.WORD_WIDTH(W), .STAGES_PER_REG(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
    polyshift_pipe #(.WORD_WIDTH(W), .STAGES_PER_REG(2)) u_dut2 (.clk_i(clk), .rst_i(rst), .bus(if2));
    polyshift_pipe #(.WORD_WIDTH(W), .STAGES_PER_REG(3)) u_dut3 (.clk_i(clk), .rst_i(rst), .bus(if3));

    // Reference written from the whole-word definitions, returns {carry, result}
    function automatic logic [8:0] ref_shift(input logic [7:0] d, input logic [6:0] c, input int s,
                                             input shift_type_t t, input shift_dir_t dir);
        logic [7:0]  r;
        logic        cy;
        logic [14:0] x;
        logic [15:0] dd;
        dd = {d, d};
        x  = (dir == LEFT) ? {d, c} : {c, d};
        r  = d;
        if (dir == LEFT) begin
            case (t)
                LOGIC, ARITH: r = d << s;
                RCL:     begin x = x << s; r = x[14:7]; end
                ROL:     begin dd = dd << s; r = dd[15:8]; end
                default: r = d;
            endcase
        end else begin
            case (t)
                LOGIC:   r = d >> s;
                ARITH:   r = $signed(d) >>> s;
                RCL:     begin x = x >> s; r = x[7:0]; end
                ROL:     begin dd = dd >> s; r = dd[7:0]; end
                default: r = d;
            endcase
        end
        if (s == 0)          cy = 1'b0;
        else if (dir == LEFT) cy = d[8-s];
        else                  cy = d[s-1];
        return {cy, r};
    endfunction

    // Single operation on an idle pipe; returns dut1 result and accept-to-valid cycles
    task automatic run_op(input logic [7:0] d, input logic [6:0] c, input logic [2:0] s,
                          input shift_type_t t, input shift_dir_t dir,
                          output logic [7:0] got_d, output logic got_c, output int lat);
        @(negedge clk);
        valid_i = 1'b1; d_i = d; c_i = c; size_i = s; type_i = t; dir_i = dir; ready_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        lat = 1;
        while (!vo[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got_d = dout[0];
        got_c = co[0];
        if (!vo[0]) lat = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (vo[k] !== 1'b0) begin n_mis++; $display("FAIL reset_valid dut%0d: got %b expected 0", k, vo[k]); end
            n_cmp++;
            if (dout[k] !== 8'h00) begin n_mis++; $display("FAIL reset_d dut%0d: got %h expected 00", k, dout[k]); end
            n_cmp++;
            if (co[k] !== 1'b0) begin n_mis++; $display("FAIL reset_carry dut%0d: got %b expected 0", k, co[k]); end
        end
        n_cmp++;
        if (ro[0] !== 1'b1) begin n_mis++; $display("FAIL reset_ready: got %b expected 1", ro[0]); end
        rst = 1'b0;
    endtask

    task automatic test_rcl_left();
        logic [7:0] gd; logic gc; int lat;
        run_op(8'b1010_0001, 7'b110_0000, 3'd3, RCL, LEFT, gd, gc, lat);
        n_cmp++;
        if (gd !== 8'b0000_1110) begin n_mis++; $display("FAIL rcl_left_d: got %h expected 0e", gd); end
        n_cmp++;
        if (gc !== 1'b1) begin n_mis++; $display("FAIL rcl_left_carry: got %b expected 1", gc); end
        n_cmp++;
        if (lat != 3) begin n_mis++; $display("FAIL rcl_left_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_right_modes();
        shift_type_t tt [3] = '{ARITH, LOGIC, RCL};
        logic [6:0]  cc [3] = '{7'h00, 7'h00, 7'h7F};
        logic [7:0]  ee [3] = '{8'hE4, 8'h24, 8'hE4};
        logic [7:0] gd; logic gc; int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(8'h90, cc[i], 3'd2, tt[i], RIGHT, gd, gc, lat);
            n_cmp++;
            if (gd !== ee[i]) begin n_mis++; $display("FAIL right_%s_d: got %h expected %h", tt[i].name(), gd, ee[i]); end
            n_cmp++;
            if (gc !== 1'b0) begin n_mis++; $display("FAIL right_%s_carry: got %b expected 0", tt[i].name(), gc); end
        end
    endtask

    task automatic test_rotate();
        shift_dir_t dd [2] = '{LEFT, RIGHT};
        logic [7:0] ee [2] = '{8'h03, 8'hC0};
        logic [7:0] gd; logic gc; int lat;
        for (int i = 0; i < 2; i++) begin
            run_op(8'h81, 7'h00, 3'd1, ROL, dd[i], gd, gc, lat);
            n_cmp++;
            if (gd !== ee[i]) begin n_mis++; $display("FAIL rol_%s_d: got %h expected %h", dd[i].name(), gd, ee[i]); end
            n_cmp++;
            if (gc !== 1'b1) begin n_mis++; $display("FAIL rol_%s_carry: got %b expected 1", dd[i].name(), gc); end
        end
    endtask

    task automatic test_zero_shift();
        logic [7:0] gd; logic gc; int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(8'hA5, 7'h5A, 3'd0, shift_type_t'(i[1:0]), shift_dir_t'(i[2]), gd, gc, lat);
            n_cmp++;
            if (gd !== 8'hA5 || gc !== 1'b0) begin
                n_mis++;
                $display("FAIL zero_shift_%0d: got d=%h c=%b expected d=a5 c=0", i, gd, gc);
            end
        end
    endtask

    task automatic test_max_shift();
        shift_type_t tt [7] = '{LOGIC, ARITH, LOGIC, RCL, RCL, ROL, ROL};
        shift_dir_t  dd [7] = '{LEFT, RIGHT, RIGHT, LEFT, RIGHT, RIGHT, LEFT};
        logic [7:0]  di [7] = '{8'h03, 8'h80, 8'hC0, 8'h01, 8'h80, 8'h01, 8'h40};
        logic [6:0]  ci [7] = '{7'h00, 7'h00, 7'h00, 7'h55, 7'h2A, 7'h00, 7'h00};
        logic [7:0]  ee [7] = '{8'h80, 8'hFF, 8'h01, 8'hD5, 8'h55, 8'h02, 8'h20};
        logic        ec [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] gd; logic gc; int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(di[i], ci[i], 3'd7, tt[i], dd[i], gd, gc, lat);
            n_cmp++;
            if (gd !== ee[i] || gc !== ec[i]) begin
                n_mis++;
                $display("FAIL max_shift_%0d: got d=%h c=%b expected d=%h c=%b", i, gd, gc, ee[i], ec[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int wr = 0;
        int rd = 0;
        logic       stall_prev = 1'b0;
        logic [7:0] held = 8'h00;
        @(negedge clk);
        for (int cyc = 0; cyc < 40; cyc++) begin
            ready_i = !(cyc >= 5 && cyc < 9);
            if (wr < 8) begin
                valid_i = 1'b1; d_i = B2B_D[wr]; c_i = 7'h00; size_i = 3'd3; type_i = ROL; dir_i = LEFT;
            end else begin
                valid_i = 1'b0;
            end
            #1;
            if (vo[0] && !ready_i) begin
                n_cmp++;
                if (ro[0] !== 1'b0) begin n_mis++; $display("FAIL b2b_ready_stall cyc %0d: got %b expected 0", cyc, ro[0]); end
                if (stall_prev) begin
                    n_cmp++;
                    if (dout[0] !== held) begin n_mis++; $display("FAIL b2b_hold cyc %0d: got %h expected %h", cyc, dout[0], held); end
                end
                held = dout[0];
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (vo[0] && ready_i) begin
                n_cmp++;
                if (rd >= 8) begin
                    n_mis++;
                    $display("FAIL b2b_extra cyc %0d: got d=%h expected no output", cyc, dout[0]);
                end else begin
                    if (dout[0] !== B2B_E[rd] || co[0] !== B2B_C[rd]) begin
                        n_mis++;
                        $display("FAIL b2b_op%0d: got d=%h c=%b expected d=%h c=%b", rd, dout[0], co[0], B2B_E[rd], B2B_C[rd]);
                    end
                    rd++;
                end
            end
            if (valid_i && ro[0]) wr++;
            @(negedge clk);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        n_cmp++;
        if (rd != 8) begin n_mis++; $display("FAIL b2b_count: got %0d expected 8", rd); end
    endtask

    task automatic test_reset_flush();
        int seen = 0;
        @(negedge clk);
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; d_i = 8'h81 + 8'(i); c_i = 7'h3C; size_i = 3'd1; type_i = ROL; dir_i = LEFT;
            @(negedge clk);
        end
        n_cmp++;
        if (vo[0] !== 1'b1) begin n_mis++; $display("FAIL flush_inflight: got valid %b expected 1", vo[0]); end
        rst = 1'b1;
        d_i = 8'h7E;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (vo[k] !== 1'b0 || dout[k] !== 8'h00 || co[k] !== 1'b0) begin
                n_mis++;
                $display("FAIL flush_reset dut%0d: got v=%b d=%h c=%b expected v=0 d=00 c=0", k, vo[k], dout[k], co[k]);
            end
        end
        rst = 1'b0;
        valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (vo[k]) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_mis++; $display("FAIL flush_drop: got %0d results expected 0", seen); end
    endtask

    task automatic test_sweep();
        int         rp [3]      = '{0, 0, 0};
        int         first [3]   = '{-1, -1, -1};
        int         lat_exp [3] = '{3, 2, 1};
        logic [8:0] ex;
        @(negedge clk);
        ready_i = 1'b1;
        for (int t = 0; t < N_SWEEP + 8; t++) begin
            for (int k = 0; k < 3; k++) begin
                if (vo[k]) begin
                    if (first[k] < 0) begin
                        first[k] = t;
                        n_cmp++;
                        if (t != lat_exp[k]) begin n_mis++; $display("FAIL sweep_latency dut%0d: got %0d expected %0d", k, t, lat_exp[k]); end
                    end
                    n_cmp++;
                    if (rp[k] >= N_SWEEP) begin
                        n_mis++;
                        $display("FAIL sweep_extra dut%0d: got d=%h expected no output", k, dout[k]);
                    end else begin
                        ex = exp_arr[rp[k]];
                        if ({co[k], dout[k]} !== ex) begin
                            n_mis++;
                            $display("FAIL sweep dut%0d op %0d: got c=%b d=%h expected c=%b d=%h", k, rp[k], co[k], dout[k], ex[8], ex[7:0]);
                        end
                        rp[k]++;
                    end
                end
            end
            if (t < N_SWEEP) begin
                valid_i = 1'b1;
                d_i     = t[7:0];
                size_i  = t[10:8];
                type_i  = shift_type_t'(t[12:11]);
                dir_i   = shift_dir_t'(t[13]);
                c_i     = 7'((t * 37) ^ (t >> 3));
                exp_arr[t] = ref_shift(d_i, c_i, int'(size_i), type_i, dir_i);
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (rp[k] != N_SWEEP) begin n_mis++; $display("FAIL sweep_count dut%0d: got %0d expected %0d", k, rp[k], N_SWEEP); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        d_i = 8'h00; c_i = 7'h00; size_i = 3'd0; type_i = LOGIC; dir_i = LEFT;
        test_reset();
        test_rcl_left();
        test_right_modes();
        test_rotate();
        test_zero_shift();
        test_max_shift();
        test_back_to_back();
        test_reset_flush();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
